pc_stall_timer: RTL and testbench
=================================

// Module: pc_stall_timer
// PURPOSE
//  Multi-channel stall timer that gates the program counter. Each channel is armed by a rising
//  edge on its request line, loads a per-request delay, and counts down to zero. pc_en is high
//  only when every channel is idle. Sits between the decode/issue logic (multi-cycle ops:
//  memory, multiply, branch refill) and the PC register's enable.
// PARAMETERS
//  NCH     2  number of independent stall channels (>=1)
//  CW      3  counter width per channel; max delay 2**CW-1
//  RETRIG  1  policy for an edge on a busy channel: 0 ignore, 1 reload D, 2 load max(D,cnt)
// PORTS
//  clk       in   1       system clock; all state changes on posedge
//  rst_n     in   1       asynchronous active-low reset
//  req       in   NCH     per-channel request; rising edge (sampled on clk) arms the channel
//  delay_in  in   NCH*CW  per-channel delay D; channel i uses bits [i*CW +: CW]
//  hold      in   1       freeze: no counter decrements this cycle
//  flush     in   1       synchronous clear of all channels; highest synchronous priority
//  pc_en     out  1       1 = PC may advance; combinational ~|busy
//  busy      out  NCH     per-channel cnt != 0
//  done      out  NCH     registered one-cycle pulse when a channel's count reaches 0
// BEHAVIOUR
//  - Reset (async, rst_n=0): cnt=0, req_q=0, done=0 => busy=0, pc_en=1 immediately.
//  - Edge detect: start[i] = req[i] & ~req_q[i]; req_q <= req every cycle.
//    req held high through reset release is detected as an edge at the first posedge.
//  - Idle channel, start with D>=1: cnt<=D at edge k. busy=1 and pc_en=0 during cycles
//    k..k+D-1 (exactly D cycles). cnt decrements once per posedge while nonzero and hold=0.
//  - At the posedge where cnt goes 1->0: done[i]<=1 for one cycle, else done<=0.
//  - Start with D=0: no effect. No stall, no done pulse.
//  - Start on a busy channel: RETRIG=0 keeps counting (start dropped). RETRIG=1 loads cnt<=D.
//    RETRIG=2 loads cnt<=max(D,cnt). A load replaces the decrement in that cycle, and no done
//    pulse is generated that cycle.
//  - hold=1: no decrement and no done pulse. Starts still load per the rules above.
//    pc_en stays low while any channel is busy.
//  - flush=1: all cnt<=0 and done<=0 at the next posedge, overriding start and hold.
//    req_q still updates, so an edge coincident with flush is lost.
//  - Channels are fully independent. pc_en = AND of ~busy over all channels.
//  - No wrap-around: the counter never decrements below 0. D is unsigned CW bits.
// STRUCTURE
//  - Package pineapple_stall_pkg: localparams RETRIG_IGNORE=0, RETRIG_RELOAD=1, RETRIG_MAX=2.
//  - Sub-module stall_channel (CW, RETRIG): req_q, cnt and done for one channel.
//    Ports: clk, rst_n, req, delay, hold, flush, busy, done.
//  - Top: generate loop of NCH stall_channel instances, plus a reduction AND for pc_en.
// TESTING
//  1. Reset: rst_n=0 with req=1 -> pc_en=1, busy=0, done=0. Release -> edge detected at
//     the first posedge.
//  2. NCH=2, CW=3, ch0 D=7 edge, ch1 idle -> pc_en low exactly 7 cycles. done[0] high for
//     1 cycle at the 7th posedge after load.
//  3. ch0 D=3 at edge k, ch1 D=5 at edge k+2 -> pc_en low cycles k..k+6. done[0] pulse
//     after edge k+3, done[1] pulse after edge k+7.
//  4. ch0 D=4, retrigger after 2 cycles with D=4: RETRIG=1 -> 6 stall cycles total;
//     RETRIG=0 -> 4; RETRIG=2 with D=1 -> 4.
//  5. ch0 D=5 with hold=1 for 3 cycles mid-count -> 8 stall cycles. Separately, flush at
//     cycle 2 -> pc_en=1 after that posedge, no done pulse.
//  6. D=0 edge -> pc_en stays 1, no done. rst_n=0 mid-count -> pc_en=1 asynchronously,
//     without waiting for clk.

Source files
------------

// File: rtl/pineapple_stall_pkg.sv
// Shared constants for the PC stall timer.
// Retrigger policies for a start edge on a busy channel.
package pineapple_stall_pkg;

  localparam int RETRIG_IGNORE = 0;
  localparam int RETRIG_RELOAD = 1;
  localparam int RETRIG_MAX    = 2;

endpackage

// File: rtl/stall_channel.sv
// One stall channel: request edge detect, countdown counter,
// and a registered done pulse on the 1->0 transition.
module stall_channel
  import pineapple_stall_pkg::*;
#(
  parameter int CW     = 3,
  parameter int RETRIG = RETRIG_RELOAD
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req,
  input  logic [CW-1:0] delay,
  input  logic          hold,
  input  logic          flush,
  output logic          busy,
  output logic          done
);

  logic          r_req_q;
  logic [CW-1:0] r_cnt;
  logic          r_done;

  logic w_start;
  logic w_idle;
  logic w_may_load;
  logic w_load;

  assign w_start = req & ~r_req_q;
  assign w_idle  = (r_cnt == '0);

  // Under the max policy a smaller D simply lets the count run on.
  assign w_may_load = w_idle
                    || (RETRIG == RETRIG_RELOAD)
                    || ((RETRIG == RETRIG_MAX) && (delay > r_cnt));

  assign w_load = w_start && (delay != '0) && w_may_load;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_req_q <= 1'b0;
      r_cnt   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_req_q <= req;
      if (flush) begin
        r_cnt  <= '0;
        r_done <= 1'b0;
      end else if (w_load) begin
        r_cnt  <= delay;
        r_done <= 1'b0;
      end else if (!hold && !w_idle) begin
        r_cnt  <= r_cnt - CW'(1);
        r_done <= (r_cnt == CW'(1));
      end else begin
        r_done <= 1'b0;
      end
    end
  end

  assign busy = ~w_idle;
  assign done = r_done;

endmodule

// File: rtl/pc_stall_timer.sv
// Multi-channel stall timer gating the PC enable;
// the PC may advance only while every channel is idle.
module pc_stall_timer
  import pineapple_stall_pkg::*;
#(
  parameter int NCH    = 2,
  parameter int CW     = 3,
  parameter int RETRIG = RETRIG_RELOAD
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NCH-1:0]    req,
  input  logic [NCH*CW-1:0] delay_in,
  input  logic              hold,
  input  logic              flush,
  output logic              pc_en,
  output logic [NCH-1:0]    busy,
  output logic [NCH-1:0]    done
);

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    stall_channel #(
      .CW     (CW),
      .RETRIG (RETRIG)
    ) u_ch (
      .clk   (clk),
      .rst_n (rst_n),
      .req   (req[g]),
      .delay (delay_in[g*CW +: CW]),
      .hold  (hold),
      .flush (flush),
      .busy  (busy[g]),
      .done  (done[g])
    );
  end

  assign pc_en = ~|busy;

endmodule

// File: tb/tb_pc_stall_timer.sv
// Directed scoreboard bench for pc_stall_timer,
// one instance per retrigger policy sharing the same stimulus.
module tb_pc_stall_timer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] req;
  logic [5:0] delay_in;
  logic       hold;
  logic       flush;

  logic       pc_en0, pc_en1, pc_en2;
  logic [1:0] busy0, busy1, busy2;
  logic [1:0] done0, done1, done2;

  typedef struct {
    string      tag;
    int         dut;
    logic [4:0] exp;
  } sb_t;

  sb_t sb[$];
  int  vectors = 0;
  int  miscompares = 0;

  localparam logic [4:0] IDLE  = 5'b1_00_00;
  localparam logic [4:0] BUSY0 = 5'b0_01_00;
  localparam logic [4:0] DONE0 = 5'b1_00_01;

  always #5 clk = ~clk;

  pc_stall_timer #(.NCH(2), .CW(3), .RETRIG(1)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .req(req), .delay_in(delay_in),
    .hold(hold), .flush(flush),
    .pc_en(pc_en0), .busy(busy0), .done(done0)
  );

  pc_stall_timer #(.NCH(2), .CW(3), .RETRIG(0)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .req(req), .delay_in(delay_in),
    .hold(hold), .flush(flush),
    .pc_en(pc_en1), .busy(busy1), .done(done1)
  );

  pc_stall_timer #(.NCH(2), .CW(3), .RETRIG(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .req(req), .delay_in(delay_in),
    .hold(hold), .flush(flush),
    .pc_en(pc_en2), .busy(busy2), .done(done2)
  );

  function automatic logic [4:0] obs(int d);
    case (d)
      0:       return {pc_en0, busy0, done0};
      1:       return {pc_en1, busy1, done1};
      default: return {pc_en2, busy2, done2};
    endcase
  endfunction

  task automatic push(string tag, int d, logic [4:0] e);
    sb_t it;
    it.tag = tag;
    it.dut = d;
    it.exp = e;
    sb.push_back(it);
  endtask

  task automatic push_all(string tag, logic [4:0] e);
    for (int d = 0; d < 3; d++) push(tag, d, e);
  endtask

  // Single ch0 stall of n cycles starting at step 0.
  task automatic push_run(string tag, int d, int n, int j);
    logic [4:0] e;
    if (j < n)       e = BUSY0;
    else if (j == n) e = DONE0;
    else             e = IDLE;
    push(tag, d, e);
  endtask

  task automatic drain();
    sb_t it;
    logic [4:0] o;
    while (sb.size() > 0) begin
      it = sb.pop_front();
      o  = obs(it.dut);
      vectors++;
      assert (o === it.exp) else begin
        miscompares++;
        $error("FAIL %s dut%0d observed=%b expected=%b",
               it.tag, it.dut, o, it.exp);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    drain();
  endtask

  initial begin
    rst_n    = 1'b0;
    req      = 2'b01;
    delay_in = {3'd0, 3'd2};
    hold     = 1'b0;
    flush    = 1'b0;

    #2;
    push_all("reset", IDLE);
    drain();
    rst_n = 1'b1;
    for (int j = 0; j < 4; j++) begin
      push_all("rst_edge", (j < 2) ? BUSY0 : (j == 2 ? DONE0 : IDLE));
      tick();
    end

    req = 2'b00;
    push_all("idle", IDLE);
    tick();
    req      = 2'b01;
    delay_in = {3'd0, 3'd7};
    for (int j = 0; j < 9; j++) begin
      push_run("d7", 0, 7, j);
      tick();
    end

    req = 2'b00;
    push_all("idle", IDLE);
    tick();
    req      = 2'b01;
    delay_in = {3'd5, 3'd3};
    push_all("two_k0", BUSY0);
    tick();
    push_all("two_k1", BUSY0);
    tick();
    req = 2'b11;
    push_all("two_k2", 5'b0_11_00);
    tick();
    push_all("two_k3", 5'b0_10_01);
    tick();
    for (int j = 4; j < 7; j++) begin
      push_all("two_ch1", 5'b0_10_00);
      tick();
    end
    push_all("two_k7", 5'b1_00_10);
    tick();
    req = 2'b00;
    push_all("two_end", IDLE);
    tick();

    delay_in = {3'd0, 3'd4};
    for (int j = 0; j < 8; j++) begin
      if (j == 0) req = 2'b01;
      if (j == 1) req = 2'b00;
      if (j == 2) req = 2'b01;
      push_run("rt_d4", 0, 6, j);
      push_run("rt_d4", 1, 4, j);
      tick();
    end

    req = 2'b00;
    push_all("idle", IDLE);
    tick();
    for (int j = 0; j < 7; j++) begin
      if (j == 0) begin req = 2'b01; delay_in = {3'd0, 3'd4}; end
      if (j == 1) req = 2'b00;
      if (j == 2) begin req = 2'b01; delay_in = {3'd0, 3'd1}; end
      push_run("rt_d1", 0, 3, j);
      push_run("rt_d1", 1, 4, j);
      push_run("rt_d1", 2, 4, j);
      tick();
    end

    req = 2'b00;
    push_all("idle", IDLE);
    tick();
    delay_in = {3'd0, 3'd5};
    for (int j = 0; j < 10; j++) begin
      if (j == 0) req = 2'b01;
      hold = (j >= 2 && j <= 4);
      for (int d = 0; d < 3; d++) push_run("hold", d, 8, j);
      tick();
    end
    hold = 1'b0;

    req = 2'b00;
    push_all("idle", IDLE);
    tick();
    for (int j = 0; j < 5; j++) begin
      if (j == 0) req = 2'b01;
      flush = (j == 2);
      push_all("flush", (j < 2) ? BUSY0 : IDLE);
      tick();
    end

    req = 2'b00;
    push_all("idle", IDLE);
    tick();
    req   = 2'b01;
    flush = 1'b1;
    push_all("flush_edge", IDLE);
    tick();
    flush = 1'b0;
    push_all("flush_lost", IDLE);
    tick();

    req = 2'b00;
    push_all("idle", IDLE);
    tick();
    req      = 2'b01;
    delay_in = {3'd0, 3'd0};
    push_all("d0", IDLE);
    tick();
    push_all("d0_after", IDLE);
    tick();

    req = 2'b00;
    push_all("idle", IDLE);
    tick();
    req      = 2'b01;
    delay_in = {3'd0, 3'd7};
    push_all("pre_rst", BUSY0);
    tick();
    push_all("pre_rst", BUSY0);
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    push_all("async_rst", IDLE);
    drain();
    req   = 2'b00;
    rst_n = 1'b1;
    push_all("post_rst", IDLE);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
